databus_arb: RTL and testbench
==============================

DATABUS_ARB -- requirements
Module: databus_arb

Interface
REQ-001 SHALL have parameter N_CH, default 3: number of cache-controller bus channels, at least 2.
REQ-002 SHALL have parameter W, default 12: bus word width.
REQ-003 SHALL have parameter VBIT, default 10: bit index of the drive/valid flag in a bus word.
REQ-004 SHALL have parameters OP_HI, default 9, and OP_LO, default 8: bounds of the snoop opcode field; an opcode of all zeros means no operation.
REQ-005 SHALL have parameter HOLD, default 2, at least 1: maximum consecutive cycles one channel keeps ownership.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port bus_in, input, N_CH*W bits: channel words; channel i occupies bits [i*W+W-1 : i*W].
REQ-009 SHALL have port bus_mem, input, W bits: memory-side word, the default source.
REQ-010 SHALL have port bus_out, output, W bits, registered: the arbitrated bus word.
REQ-011 SHALL have port grant, output, N_CH bits, registered: one-hot owner of bus_out, all zero when memory drives.
REQ-012 SHALL have port mem_sel, output, 1 bit, registered: high when bus_out carries bus_mem.
REQ-013 SHALL have port busy, output, 1 bit, registered: high while the state is OWN.

Function
REQ-014 SHALL assert req[i] only when channel i has bit VBIT = 1 and a nonzero opcode field [OP_HI:OP_LO].
REQ-015 SHALL implement states IDLE (no owner) and OWN (owner index, hold counter cnt of width clog2(HOLD), minimum 1).
REQ-016 SHALL define keep as: state OWN, req[owner] = 1 and cnt != 0.
REQ-017 SHALL, when keep is true, keep the owner unchanged, decrement cnt and stay in OWN.
REQ-018 SHALL, when keep is false and any request is active, grant the arbitration winner, load cnt = HOLD-1 and enter OWN; this re-arbitrates in the same cycle, with no bubble.
REQ-019 SHALL, when keep is false and no request is active, enter IDLE.
REQ-020 SHALL register bus_out, grant, mem_sel and busy from the next-state decision, giving 1-cycle latency from bus_in/bus_mem to bus_out.
REQ-021 SHALL, while in OWN, update bus_out every cycle to the owner's current word, not a frozen copy.
REQ-022 SHALL, while in IDLE, update bus_out every cycle to bus_mem, with mem_sel = 1 and grant = 0.
REQ-023 SHALL, if the owner drops its request before cnt reaches 0, release ownership early in that same decision cycle.
REQ-024 SHALL, with HOLD = 1, re-arbitrate every cycle.
REQ-025 SHALL never assert more than one grant bit, and SHALL never have mem_sel = 1 while any grant bit is set.

Reset
REQ-026 SHALL, on a clock edge with rst_n = 0, set state IDLE, cnt = 0, rr_ptr = 0, bus_out = 0, grant = 0, mem_sel = 0 and busy = 0.
REQ-027 SHALL, on reset during OWN, drop ownership immediately with no completion of the hold.
REQ-028 SHALL make its first post-reset decision on the first edge with rst_n = 1.

Configuration
REQ-029 SHALL, with macro DATABUS_ARB_RR_EN defined, pick the winner as the first requester found searching upward from rr_ptr with wrap-around.
REQ-030 SHALL, with DATABUS_ARB_RR_EN defined, set rr_ptr to (winner+1) mod N_CH on every new grant, including a grant to the same channel.
REQ-031 SHALL, without DATABUS_ARB_RR_EN, use fixed priority where the lowest index wins, and SHALL have no rr_ptr register.

Verification
(All scenarios use N_CH=3, W=12, HOLD=2.)
REQ-032 SHALL verify reset: rst_n = 0 for 2 edges with all inputs 12'h5A3 -> bus_out = 0, grant = 0, mem_sel = 0, busy = 0.
REQ-033 SHALL verify non-requests: ch0 = 12'h4A3 (opcode 0), ch1 = 12'h1A3 (valid 0), bus_mem = 12'h0FF -> bus_out = 12'h0FF one cycle later, mem_sel = 1.
REQ-034 SHALL verify hold and rotation (RR_EN): ch0 and ch2 = 12'h5A3/12'h6B4 held steady -> grant 001, 001, 100, 100, 001...; bus_out follows with 1-cycle latency.
REQ-035 SHALL verify fixed priority (no RR_EN): same stimulus as REQ-034 -> grant = 001 continuously.
REQ-036 SHALL verify early release: ch1 owns, drops its request after 1 cycle while ch2 requests -> grant = 100 on the next edge with no bus_mem bubble.
REQ-037 SHALL verify mid-ownership reset: rst_n = 0 while busy = 1 -> all outputs 0 next edge; after release, the lowest-index requester wins (rr_ptr = 0).

Source files
------------

// File: rtl/databus_arb.sv
// Snoop-bus arbiter: forwards one requesting cache channel (or memory when idle) onto a registered bus.
// Optional `DATABUS_ARB_RR_EN selects round-robin winner search; default build is fixed lowest-index priority.
module databus_arb #(
    parameter int N_CH  = 3,
    parameter int W     = 12,
    parameter int VBIT  = 10,
    parameter int OP_HI = 9,
    parameter int OP_LO = 8,
    parameter int HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] bus_in,
    input  logic [W-1:0]      bus_mem,
    output logic [W-1:0]      bus_out,
    output logic [N_CH-1:0]   grant,
    output logic              mem_sel,
    output logic              busy
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [0:0] {IDLE, OWN} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [CW-1:0]   cnt;
`ifdef DATABUS_ARB_RR_EN
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   nxt_rr;
`endif

    logic [N_CH-1:0] req;
    logic [IW-1:0]   win;
    logic            keep;
    state_t          nxt_state;
    logic [IW-1:0]   nxt_owner;
    logic [CW-1:0]   nxt_cnt;
    logic [N_CH-1:0] nxt_grant;
    logic [W-1:0]    nxt_word;

    function automatic logic is_req(input logic [W-1:0] wd);
        return wd[VBIT] && (|wd[OP_HI:OP_LO]);
    endfunction

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            req[i] = is_req(bus_in[i*W +: W]);
        end
    end

    always_comb begin
        int j;
        logic found;
        j     = 0;
        found = 1'b0;
        win   = '0;
`ifdef DATABUS_ARB_RR_EN
        // Search upward from rr_ptr, wrapping past the top channel.
        for (int k = 0; k < N_CH; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_CH) j = j - N_CH;
            if (!found && req[j]) begin
                win   = IW'(j);
                found = 1'b1;
            end
        end
`else
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) win = IW'(i);
        end
`endif
    end

    assign keep = (state == OWN) && req[owner] && (cnt != '0);

    always_comb begin
        nxt_state = IDLE;
        nxt_owner = owner;
        nxt_cnt   = '0;
`ifdef DATABUS_ARB_RR_EN
        nxt_rr    = rr_ptr;
`endif
        if (keep) begin
            nxt_state = OWN;
            nxt_cnt   = cnt - CW'(1);
        end else if (|req) begin
            // A dropped or expired owner is replaced in the same decision, so no memory bubble.
            nxt_state = OWN;
            nxt_owner = win;
            nxt_cnt   = CW'(HOLD - 1);
`ifdef DATABUS_ARB_RR_EN
            nxt_rr    = (int'(win) == N_CH - 1) ? '0 : win + IW'(1);
`endif
        end
    end

    always_comb begin
        nxt_grant = '0;
        nxt_word  = bus_mem;
        if (nxt_state == OWN) begin
            for (int i = 0; i < N_CH; i++) begin
                if (nxt_owner == IW'(i)) begin
                    nxt_grant[i] = 1'b1;
                    nxt_word     = bus_in[i*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            cnt     <= '0;
`ifdef DATABUS_ARB_RR_EN
            rr_ptr  <= '0;
`endif
            bus_out <= '0;
            grant   <= '0;
            mem_sel <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= nxt_state;
            owner   <= nxt_owner;
            cnt     <= nxt_cnt;
`ifdef DATABUS_ARB_RR_EN
            rr_ptr  <= nxt_rr;
`endif
            bus_out <= nxt_word;
            grant   <= nxt_grant;
            mem_sel <= (nxt_state == IDLE);
            busy    <= (nxt_state == OWN);
        end
    end

endmodule

// File: tb/tb_databus_arb.sv
// Directed bench for databus_arb (N_CH=3, W=12, HOLD=2); expectations follow `DATABUS_ARB_RR_EN when defined.
module tb_databus_arb;

    logic        clk;
    logic        rst_n;
    logic [11:0] ch [3];
    logic [35:0] bus_in;
    logic [11:0] bus_mem;
    logic [11:0] bus_out;
    logic [2:0]  grant;
    logic        mem_sel;
    logic        busy;

    int errs   = 0;
    int checks = 0;

    assign bus_in = {ch[2], ch[1], ch[0]};

    databus_arb #(
        .N_CH(3), .W(12), .VBIT(10), .OP_HI(9), .OP_LO(8), .HOLD(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus_in(bus_in),
        .bus_mem(bus_mem),
        .bus_out(bus_out),
        .grant(grant),
        .mem_sel(mem_sel),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [11:0] eo, input logic [2:0] eg,
                              input logic em, input logic eb);
        check({tag, ".bus_out"}, 32'(bus_out), 32'(eo));
        check({tag, ".grant"},   32'(grant),   32'(eg));
        check({tag, ".mem_sel"}, 32'(mem_sel), 32'(em));
        check({tag, ".busy"},    32'(busy),    32'(eb));
    endtask

    logic [2:0]  exp_g [6];
    logic [11:0] exp_w;

    initial begin
        // Reset with every input carrying a valid request word.
        rst_n   = 1'b0;
        ch[0]   = 12'h5A3;
        ch[1]   = 12'h5A3;
        ch[2]   = 12'h5A3;
        bus_mem = 12'h5A3;
        cyc();
        cyc();
        check_outs("reset", 12'h000, 3'b000, 1'b0, 1'b0);

        // Zero opcode and cleared valid bit are not requests.
        rst_n   = 1'b1;
        ch[0]   = 12'h4A3;
        ch[1]   = 12'h1A3;
        ch[2]   = 12'h000;
        bus_mem = 12'h0FF;
        cyc();
        check_outs("noreq", 12'h0FF, 3'b000, 1'b1, 1'b0);
        bus_mem = 12'h123;
        cyc();
        check("idle_follow.bus_out", 32'(bus_out), 32'h123);

        // Two steady requesters: hold then rotate, or fixed priority.
`ifdef DATABUS_ARB_RR_EN
        exp_g = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b001, 3'b001};
`else
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        ch[0] = 12'h5A3;
        ch[2] = 12'h6B4;
        for (int i = 0; i < 6; i++) begin
            cyc();
            exp_w = (exp_g[i] == 3'b001) ? 12'h5A3 : 12'h6B4;
            check_outs($sformatf("arb%0d", i), exp_w, exp_g[i], 1'b0, 1'b1);
        end

        // All requests withdrawn: back to memory.
        ch[0] = 12'h000;
        ch[1] = 12'h000;
        ch[2] = 12'h000;
        bus_mem = 12'h0AA;
        cyc();
        check_outs("release", 12'h0AA, 3'b000, 1'b1, 1'b0);

        // Owner's word is forwarded live during the hold.
        ch[1] = 12'h5C1;
        cyc();
        check_outs("ch1_own", 12'h5C1, 3'b010, 1'b0, 1'b1);
        ch[1] = 12'h5C2;
        cyc();
        check_outs("ch1_live", 12'h5C2, 3'b010, 1'b0, 1'b1);
        ch[1] = 12'h000;
        cyc();
        check("gap.mem_sel", 32'(mem_sel), 32'd1);

        // Early release: ch1 drops after one cycle, ch2 takes over without a memory cycle.
        ch[1] = 12'h5C1;
        cyc();
        check("early_own.grant", 32'(grant), 32'b010);
        ch[1] = 12'h1C1;
        ch[2] = 12'h6B4;
        cyc();
        check_outs("early_rel", 12'h6B4, 3'b100, 1'b0, 1'b1);

        // Hand over to ch0 so a round-robin pointer would sit past channel 0.
        ch[0] = 12'h5A3;
        ch[2] = 12'h000;
        cyc();
        check_outs("ch0_own", 12'h5A3, 3'b001, 1'b0, 1'b1);

        // Reset mid-ownership, then lowest-index requester wins.
        ch[2] = 12'h6B4;
        rst_n = 1'b0;
        cyc();
        check_outs("mid_reset", 12'h000, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc();
        check_outs("post_reset", 12'h5A3, 3'b001, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Grant stays one-hot and never overlaps with the memory source.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!$onehot0(grant) || (mem_sel && (grant != 3'b000))) begin
                check("grant_excl", {29'd0, grant}, {29'd0, mem_sel ? 3'b000 : grant});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
